// File: rtl/cla_sub_pkg.sv
// Shared definitions for the pipelined CLA subtractor.
// Default widths, the chunk-width helper and the stage-register record layout.
package cla_sub_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefStages    = 4;

  // Bits handled by each pipeline stage.
  function automatic int unsigned chunk_width(int unsigned data_width, int unsigned stages);
    return data_width / stages;
  endfunction

  localparam int unsigned DefChunk = chunk_width(DefDataWidth, DefStages);

  // One stage register at default widths: operands still to be consumed, partial difference,
  // carry into the next chunk, accumulated zero flag and overflow of the chunk just computed.
  typedef struct packed {
    logic [DefDataWidth-1:0] a;
    logic [DefDataWidth-1:0] b;
    logic [DefDataWidth-1:0] diff;
    logic                    carry;
    logic                    zero;
    logic                    ovf;
  } stage_t;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder group.
// Ports: a_i, b_i addends; c_i carry in; sum_o sum; c_o carry out; c3_o carry into bit 3.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o,
  output logic       c3_o
);

  logic [3:0] g, p;
  logic [4:0] c;

  gp_gen #(
    .Width(4)
  ) u_gp (
    .a_i(a_i),
    .b_i(b_i),
    .g_o(g),
    .p_o(p)
  );

  always_comb begin
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & c_i);
  end

  assign sum_o = p ^ c[3:0];
  assign c_o   = c[4];
  assign c3_o  = c[3];

endmodule

// File: rtl/gp_gen.sv
// Generate/propagate terms for carry-lookahead addition.
// Ports: a_i, b_i operands; g_o = a&b, p_o = a^b, bitwise.
module gp_gen #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] g_o,
  output logic [Width-1:0] p_o
);

  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

endmodule

// File: rtl/sub_chunk.sv
// Combinational chunk of the subtractor: diff = a + ~b + cin, built from 4-bit CLA groups
// with the group carries rippled between them.
// Ports: a_i, b_i chunk operands; cin_i carry in (= ~borrow in); diff_o chunk result;
// cout_o carry out of the chunk MSB; cmsb_o carry into the chunk MSB; zero_o diff_o == 0.
module sub_chunk #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] diff_o,
  output logic             cout_o,
  output logic             cmsb_o,
  output logic             zero_o
);

  localparam int unsigned Groups = Width / 4;

  logic [Width-1:0]  b_n;
  logic [Groups:0]   c;
  logic [Groups-1:0] group_c3;
  logic              unused_group_c3;

  assign b_n  = ~b_i;
  assign c[0] = cin_i;

  for (genvar g = 0; g < Groups; g++) begin : gen_group
    cla_4bit u_cla (
      .a_i  (a_i[4*g +: 4]),
      .b_i  (b_n[4*g +: 4]),
      .c_i  (c[g]),
      .sum_o(diff_o[4*g +: 4]),
      .c_o  (c[g+1]),
      .c3_o (group_c3[g])
    );
  end

  // Only the top group's bit-3 carry is the chunk MSB carry-in.
  assign unused_group_c3 = ^group_c3;

  assign cout_o = c[Groups];
  assign cmsb_o = group_c3[Groups-1];
  assign zero_o = ~|diff_o;

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined valid/ready subtractor: diff = A - B - bin, one chunk per stage with the borrow
// (as an inverted carry) rippled through the stage registers.
// Ports: clk, rst (sync, active high); in_valid/in_ready with a_i, b_i, bin_i operands;
// out_valid/out_ready with diff_o, bout_o (unsigned borrow), ovf_o (signed overflow),
// zero_o (diff_o == 0). in_ready depends combinationally on out_ready.
module cla_sub_pipe
  import cla_sub_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned STAGES     = DefStages
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  bin_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff_o,
  output logic                  bout_o,
  output logic                  ovf_o,
  output logic                  zero_o
);

  localparam int unsigned Chunk = chunk_width(DATA_WIDTH, STAGES);

  logic [DATA_WIDTH-1:0] a_q [STAGES];
  logic [DATA_WIDTH-1:0] a_d [STAGES];
  logic [DATA_WIDTH-1:0] b_q [STAGES];
  logic [DATA_WIDTH-1:0] b_d [STAGES];
  logic [DATA_WIDTH-1:0] diff_q [STAGES];
  logic [DATA_WIDTH-1:0] diff_d [STAGES];
  logic [STAGES-1:0]     carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, vld_q, vld_d;

  // Per-stage inputs: stage 0 reads the ports, stage s reads register s-1.
  logic [DATA_WIDTH-1:0] a_in [STAGES];
  logic [DATA_WIDTH-1:0] b_in [STAGES];
  logic [DATA_WIDTH-1:0] diff_in [STAGES];
  logic [STAGES-1:0]     cin, zero_in;

  logic [Chunk-1:0]  ch_diff [STAGES];
  logic [STAGES-1:0] ch_cout, ch_cmsb, ch_zero;

  logic stall;
  logic unused_tail;

  assign out_valid = vld_q[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    a_in[0]    = a_i;
    b_in[0]    = b_i;
    diff_in[0] = '0;
    cin[0]     = ~bin_i;
    zero_in[0] = 1'b1;
    vld_d[0]   = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      a_in[s]    = a_q[s-1];
      b_in[s]    = b_q[s-1];
      diff_in[s] = diff_q[s-1];
      cin[s]     = carry_q[s-1];
      zero_in[s] = zero_q[s-1];
      vld_d[s]   = vld_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : gen_stage
    sub_chunk #(
      .Width(Chunk)
    ) u_chunk (
      .a_i   (a_in[s][s*Chunk +: Chunk]),
      .b_i   (b_in[s][s*Chunk +: Chunk]),
      .cin_i (cin[s]),
      .diff_o(ch_diff[s]),
      .cout_o(ch_cout[s]),
      .cmsb_o(ch_cmsb[s]),
      .zero_o(ch_zero[s])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      a_d[s]                     = a_in[s];
      b_d[s]                     = b_in[s];
      diff_d[s]                  = diff_in[s];
      diff_d[s][s*Chunk +: Chunk] = ch_diff[s];
      carry_d[s]                 = ch_cout[s];
      ovf_d[s]                   = ch_cmsb[s] ^ ch_cout[s];
      zero_d[s]                  = zero_in[s] & ch_zero[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]    <= '0;
        b_q[s]    <= '0;
        diff_q[s] <= '0;
      end
      // Carry resets high so bout_o (its inverse) reads 0 out of reset.
      carry_q <= '1;
      zero_q  <= '0;
      ovf_q   <= '0;
      vld_q   <= '0;
    end else if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]    <= a_d[s];
        b_q[s]    <= b_d[s];
        diff_q[s] <= diff_d[s];
      end
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  // Last-stage operands and non-final overflow bits are never consumed.
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], ovf_q};

  assign diff_o = diff_q[STAGES-1];
  assign bout_o = ~carry_q[STAGES-1];
  assign ovf_o  = ovf_q[STAGES-1];
  assign zero_o = zero_q[STAGES-1];

endmodule
